ram_reader: RTL and testbench

- Read-side counterpart to the byte writer that loads the data RAM.
- On a start pulse, reads `len` consecutive bytes from the data RAM, starting at `base_addr`.
- Presents each byte to a downstream consumer (display/serial) over a valid/ready handshake.
- Takes the RAM address/read port only while `bus_req` is high; `bus_req` drives the RAM address mux select.

---
 rtl/ram_reader_pkg.sv | 32 +++
 rtl/rd_checksum.sv | 37 +++
 rtl/ram_reader.sv | 199 +++++++++++++++++++
 tb/tb_ram_reader.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_reader_pkg.sv
// Purpose: shared types and constants for the RAM read-out engine.
// Latency: n/a (declarations only).
// Backpressure: n/a. RAM_READER_CHECKSUM_EN adds the CSUM state.
package ram_reader_pkg;

   // Largest supported RAM read latency; sizes the latency counter
   localparam int RD_LAT_MAX = 3;
   localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX + 1);

   // Transfer length that completes at once without touching the RAM
   localparam int LEN_ZERO   = 0;

`ifdef RAM_READER_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      OUT  = 3'd3,
      CSUM = 3'd4,
      DONE = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      OUT  = 3'd3,
      DONE = 3'd5
   } state_t;
`endif

endpackage

// File: rtl/rd_checksum.sv
// Purpose: 8-bit running sum (mod 256) of the bytes handed to the consumer.
// Latency: sum reflects an add one cycle after it is requested.
// Backpressure: none; the caller asserts add only on a completed handshake.
module rd_checksum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       add,
   input  logic [7:0] din,
   output logic [7:0] sum
);

   logic [7:0] sum_d;
   logic [7:0] sum_q;

   // Clear wins over add so a new transfer always starts from zero
   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = 8'd0;
      end else if (add) begin
         sum_d = sum_q + din;
      end
   end

   // Accumulator register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= 8'd0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule

// File: rtl/ram_reader.sv
// Purpose: streams len bytes from the data RAM at base_addr to a valid/ready consumer.
// Latency: first out_valid 2+RD_LAT cycles after start is raised; 2+RD_LAT cycles per byte.
// Backpressure: out_valid/out_data held until out_ready; RAM released while waiting.
// Option: RAM_READER_CHECKSUM_EN appends a mod-256 sum beat carrying out_last.
module ram_reader
   import ram_reader_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int LEN_W  = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              bus_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              done
);

   // Out-of-range latencies are clamped into 1..RD_LAT_MAX
   localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

   state_t                state_d, state_q;
   logic [ADDR_W-1:0]     addr_d, addr_q;
   logic [LEN_W-1:0]      rem_d, rem_q;
   logic [LAT_CNT_W-1:0]  lat_d, lat_q;
   logic [DATA_W-1:0]     out_data_d, out_data_q;
   logic                  out_valid_d, out_valid_q;
   logic                  done_d, done_q;
   logic                  busy_d, busy_q;

   logic                  accept;
   logic                  zero_len;
   logic                  hs;
   logic                  lat_exp;
   logic                  last_data;

   assign accept    = (state_q == IDLE) && start && (len != LEN_W'(LEN_ZERO));
   assign zero_len  = (state_q == IDLE) && start && (len == LEN_W'(LEN_ZERO));
   assign hs        = out_valid_q && out_ready;
   assign lat_exp   = (lat_q == LAT_CNT_W'(LAT - 1));
   assign last_data = (rem_q == LEN_W'(1));

`ifdef RAM_READER_CHECKSUM_EN
   logic [7:0] csum;

   rd_checksum u_csum (
      .clk (clk),
      .rst (rst),
      .clr (accept),
      .add ((state_q == OUT) && hs),
      .din (out_data_q[7:0]),
      .sum (csum)
   );
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: one RAM read per byte, then wait for the consumer
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = REQ;
         REQ:  state_d = WAIT;
         WAIT: if (lat_exp) state_d = OUT;
         OUT: begin
            if (hs) begin
               if (!last_data) begin
                  state_d = REQ;
               end else begin
`ifdef RAM_READER_CHECKSUM_EN
                  state_d = CSUM;
`else
                  state_d = DONE;
`endif
               end
            end
         end
`ifdef RAM_READER_CHECKSUM_EN
         CSUM: if (hs) state_d = DONE;
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: address/length, latency count, output beat, done pulse
   always_comb begin
      addr_d      = addr_q;
      rem_d       = rem_q;
      lat_d       = lat_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      busy_d      = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d = base_addr;
               rem_d  = len;
            end else if (zero_len) begin
               done_d = 1'b1;
            end
         end
         REQ: lat_d = '0;
         WAIT: begin
            if (lat_exp) begin
               out_data_d  = mem_rdata;
               out_valid_d = 1'b1;
            end else begin
               lat_d = lat_q + LAT_CNT_W'(1);
            end
         end
         OUT: begin
            if (hs) begin
               if (!last_data) begin
                  out_valid_d = 1'b0;
                  addr_d      = addr_q + ADDR_W'(1);
                  rem_d       = rem_q - LEN_W'(1);
               end else begin
`ifdef RAM_READER_CHECKSUM_EN
                  // Valid stays up: the sum beat follows with no RAM access
                  out_valid_d = 1'b1;
`else
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
`endif
               end
            end
         end
`ifdef RAM_READER_CHECKSUM_EN
         CSUM: begin
            if (hs) begin
               out_valid_d = 1'b0;
               done_d      = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q      <= '0;
         rem_q       <= '0;
         lat_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         lat_q       <= lat_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   // Outputs: RAM is owned only in REQ/WAIT, so the writer gets it back during OUT
   always_comb begin
      bus_req   = (state_q == REQ) || (state_q == WAIT);
      mem_addr  = addr_q;
      busy      = busy_q;
      done      = done_q;
      out_valid = out_valid_q;
      out_data  = out_data_q;
`ifdef RAM_READER_CHECKSUM_EN
      out_last  = 1'b0;
      if (state_q == CSUM) begin
         out_data = DATA_W'(csum);
         out_last = 1'b1;
      end
`else
      out_last  = (state_q == OUT) && last_data;
`endif
   end

endmodule

// File: tb/tb_ram_reader.sv
`timescale 1ns/1ps
module tb_ram_reader;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 8;
   localparam int RD_LAT = 2;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  len;
   logic              busy, bus_req, out_valid, out_ready, out_last, done;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata, out_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] ram [0:65535];
   logic [7:0] rd_pipe [RD_LAT];

   beat_t exp_q[$];
   int    rp = 0;

   beat_t       obs_q[$];
   int          obs_hcyc[$];
   logic [15:0] obs_addr[$];
   int          obs_vcyc[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          breq_err = 0;
   int          stab_err = 0;
   logic        pv = 1'b0, pr = 1'b0, pbr = 1'b0;
   logic [7:0]  pd = 8'd0;

   always #5 clk = ~clk;

   ram_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .bus_req(bus_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .done(done)
   );

   // RAM model with RD_LAT registered read stages
   always @(posedge clk) begin
      rd_pipe[0] <= ram[mem_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mem_rdata = rd_pipe[RD_LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: records beats, read addresses, valid rises, done pulses and protocol slips
   always @(negedge clk) begin
      if (rst) begin
         if (out_valid && out_ready) begin
            obs_q.push_back('{d: out_data, l: out_last});
            obs_hcyc.push_back(cyc);
         end
         if (bus_req && !pbr) obs_addr.push_back(mem_addr);
         if (out_valid && !pv) obs_vcyc.push_back(cyc);
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
         if (out_valid && bus_req) breq_err <= breq_err + 1;
         if (pv && !pr && (!out_valid || out_data !== pd)) stab_err <= stab_err + 1;
         pv  <= out_valid;
         pr  <= out_ready;
         pd  <= out_data;
         pbr <= bus_req;
      end else begin
         pv  <= 1'b0;
         pbr <= 1'b0;
      end
   end

   task automatic start_xfer(input logic [15:0] b, input logic [7:0] n, output int s0);
      @(posedge clk); #1;
      start = 1'b1; base_addr = b; len = n; s0 = cyc;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 16'($urandom); len = 8'($urandom);
   endtask

   task automatic push_exp(input logic [15:0] b, input int n);
      logic [15:0] a;
`ifdef RAM_READER_CHECKSUM_EN
      logic [7:0] s = 8'd0;
`endif
      for (int i = 0; i < n; i++) begin
         a = b + 16'(i);
`ifdef RAM_READER_CHECKSUM_EN
         s = s + ram[a];
         exp_q.push_back('{d: ram[a], l: 1'b0});
`else
         exp_q.push_back('{d: ram[a], l: (i == n - 1)});
`endif
      end
`ifdef RAM_READER_CHECKSUM_EN
      exp_q.push_back('{d: s, l: 1'b1});
`endif
   endtask

   task automatic wait_done(input int target, input int budget, output bit to);
      to = 1'b1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done_cnt >= target) begin
            to = 1'b0;
            break;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      int b0;
      rst = 1'b1; start = 1'b0; out_ready = 1'b0; base_addr = '0; len = '0;
      #2 rst = 1'b0;
      @(negedge clk); start = 1'b1; len = 8'd4;
      @(negedge clk);
      checks++;
      if ({busy, bus_req, out_valid, out_last, done} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, bus_req, out_valid, out_last, done});
      end
      checks++;
      if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", mem_addr); end
      checks++;
      if (out_data !== 8'h0) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
      start = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      b0 = 0;
      for (int k = 0; k < 4; k++) begin @(negedge clk); if (busy !== 1'b0) b0++; end
      checks++;
      if (b0 != 0) begin errors++; $display("FAIL reset_start_ignored busy_cycles %0d want 0", b0); end
   endtask

   task automatic test_basic();
      int s0, d0, b0; bit to; beat_t e;
      out_ready = 1'b1;
      rp = obs_q.size(); d0 = done_cnt; b0 = breq_err;
      push_exp(16'h0010, 4);
      start_xfer(16'h0010, 8'd4, s0);
      wait_done(d0 + 1, 200, to);
      checks++;
      if (to) begin errors++; $display("FAIL basic_timeout got no done want done"); end
      checks++;
      if (obs_q.size() - rp != exp_q.size()) begin
         errors++; $display("FAIL basic_count got %0d want %0d", obs_q.size() - rp, exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rp >= obs_q.size()) begin errors++; $display("FAIL basic_beat missing want %h", e); end
         else if (obs_q[rp] !== e) begin errors++; $display("FAIL basic_beat got %h want %h", obs_q[rp], e); end
         rp++;
      end
      checks++;
      if (obs_hcyc.size() == 0 || done_cyc - obs_hcyc[obs_hcyc.size()-1] != 1) begin
         errors++; $display("FAIL basic_done_timing got %0d want 1", done_cyc - obs_hcyc[obs_hcyc.size()-1]);
      end
      checks++;
      if (breq_err != b0) begin errors++; $display("FAIL basic_busreq_in_out got %0d want 0", breq_err - b0); end
   endtask

   task automatic test_backpressure();
      int s0, d0, a0, st0; bit to, seen; beat_t e;
      out_ready = 1'b1;
      rp = obs_q.size(); d0 = done_cnt; st0 = stab_err;
      push_exp(16'h0010, 4);
      start_xfer(16'h0010, 8'd4, s0);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      @(posedge clk); #1 out_ready = 1'b0;
      for (int k = 0; k < 20 && seen; k++) begin @(negedge clk); if (out_valid) break; end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %b want 1", out_valid); end
      a0 = obs_addr.size();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            errors++; $display("FAIL bp_hold cycle %0d got v=%b d=%h want v=1 d=22", k, out_valid, out_data);
         end
         @(negedge clk);
      end
      checks++;
      if (obs_addr.size() != a0) begin errors++; $display("FAIL bp_addr_advance got %0d want 0", obs_addr.size() - a0); end
      out_ready = 1'b1;
      wait_done(d0 + 1, 200, to);
      checks++;
      if (to) begin errors++; $display("FAIL bp_timeout got no done want done"); end
      checks++;
      if (stab_err != st0) begin errors++; $display("FAIL bp_stability got %0d want 0", stab_err - st0); end
      checks++;
      if (obs_q.size() - rp != exp_q.size()) begin
         errors++; $display("FAIL bp_count got %0d want %0d", obs_q.size() - rp, exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rp >= obs_q.size()) begin errors++; $display("FAIL bp_beat missing want %h", e); end
         else if (obs_q[rp] !== e) begin errors++; $display("FAIL bp_beat got %h want %h", obs_q[rp], e); end
         rp++;
      end
   endtask

   task automatic test_zero_len_busy();
      int s0, d0, bad; bit to, seen; beat_t e;
      out_ready = 1'b1;
      rp = obs_q.size();
      start_xfer(16'h0010, 8'd0, s0);
      @(negedge clk);
      checks++;
      if ({done, busy, out_valid} !== 3'b100) begin
         errors++; $display("FAIL zl_pulse got %b want 100", {done, busy, out_valid});
      end
      @(negedge clk);
      checks++;
      if ({done, busy, out_valid} !== 3'b000) begin
         errors++; $display("FAIL zl_after got %b want 000", {done, busy, out_valid});
      end
      d0 = done_cnt;
      push_exp(16'h0010, 2);
      start_xfer(16'h0010, 8'd2, s0);
      start_xfer(16'h0000, 8'd5, s0);
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin @(negedge clk); if (done === 1'b1) begin seen = 1'b1; break; end end
      checks++;
      if (!seen) begin errors++; $display("FAIL zl_busy_done got no done want done"); end
      start = 1'b1; base_addr = 16'h0000; len = 8'd3;
      @(posedge clk); #1 start = 1'b0;
      bad = 0;
      for (int k = 0; k < 8; k++) begin @(negedge clk); if (busy !== 1'b0 || out_valid !== 1'b0) bad++; end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL start_in_done busy_cycles %0d want 0", bad); end
      checks++;
      if (done_cnt != d0 + 1) begin errors++; $display("FAIL zl_busy_dones got %0d want 1", done_cnt - d0); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rp >= obs_q.size()) begin errors++; $display("FAIL busy_beat missing want %h", e); end
         else if (obs_q[rp] !== e) begin errors++; $display("FAIL busy_beat got %h want %h", obs_q[rp], e); end
         rp++;
      end
      checks++;
      if (obs_q.size() != rp) begin errors++; $display("FAIL busy_extra_beats got %0d want 0", obs_q.size() - rp); end
      to = 1'b0;
   endtask

   task automatic test_wrap_latency();
      int s0, d0, a0, v0; bit to; beat_t e;
      logic [15:0] exp_a [3];
      exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000;
      ram[16'hFFFE] = 8'hA1; ram[16'hFFFF] = 8'hB2; ram[16'h0000] = 8'hC3;
      out_ready = 1'b1;
      rp = obs_q.size(); d0 = done_cnt; a0 = obs_addr.size(); v0 = obs_vcyc.size();
      push_exp(16'hFFFE, 3);
      start_xfer(16'hFFFE, 8'd3, s0);
      wait_done(d0 + 1, 200, to);
      checks++;
      if (to) begin errors++; $display("FAIL wrap_timeout got no done want done"); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (a0 + i >= obs_addr.size()) begin errors++; $display("FAIL wrap_addr %0d missing want %h", i, exp_a[i]); end
         else if (obs_addr[a0+i] !== exp_a[i]) begin
            errors++; $display("FAIL wrap_addr %0d got %h want %h", i, obs_addr[a0+i], exp_a[i]);
         end
      end
      checks++;
      if (v0 >= obs_vcyc.size() || obs_vcyc[v0] - s0 != 2 + RD_LAT) begin
         errors++; $display("FAIL first_valid_latency got %0d want %0d", (v0 < obs_vcyc.size()) ? obs_vcyc[v0] - s0 : -1, 2 + RD_LAT);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rp >= obs_q.size()) begin errors++; $display("FAIL wrap_beat missing want %h", e); end
         else if (obs_q[rp] !== e) begin errors++; $display("FAIL wrap_beat got %h want %h", obs_q[rp], e); end
         rp++;
      end
   endtask

   task automatic test_reset_mid();
      int s0, d0, a0; bit to, seen; beat_t e;
      out_ready = 1'b1;
      a0 = obs_addr.size(); d0 = done_cnt;
      start_xfer(16'h0010, 8'd4, s0);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin @(negedge clk); if (obs_addr.size() >= a0 + 2) begin seen = 1'b1; break; end end
      checks++;
      if (!seen) begin errors++; $display("FAIL rm_second_req got none want one"); end
      @(posedge clk); #2 rst = 1'b0;
      #1;
      checks++;
      if ({busy, bus_req, out_valid, out_last, done} !== 5'b0 || mem_addr !== 16'h0 || out_data !== 8'h0) begin
         errors++; $display("FAIL rm_async_clear got ctrl=%b addr=%h data=%h want 0", {busy, bus_req, out_valid, out_last, done}, mem_addr, out_data);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (done_cnt != d0 || busy !== 1'b0) begin
         errors++; $display("FAIL rm_no_done got dones=%0d busy=%b want 0 0", done_cnt - d0, busy);
      end
      ram[16'h0020] = 8'h5A; ram[16'h0021] = 8'hA5;
      rp = obs_q.size(); d0 = done_cnt; exp_q.delete();
      push_exp(16'h0020, 2);
      start_xfer(16'h0020, 8'd2, s0);
      wait_done(d0 + 1, 200, to);
      checks++;
      if (to) begin errors++; $display("FAIL rm_restart_timeout got no done want done"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rp >= obs_q.size()) begin errors++; $display("FAIL rm_beat missing want %h", e); end
         else if (obs_q[rp] !== e) begin errors++; $display("FAIL rm_beat got %h want %h", obs_q[rp], e); end
         rp++;
      end
   endtask

`ifdef RAM_READER_CHECKSUM_EN
   task automatic test_checksum();
      int s0, d0; bit to; beat_t e;
      ram[16'h0100] = 8'hF0; ram[16'h0101] = 8'h20;
      out_ready = 1'b1;
      rp = obs_q.size(); d0 = done_cnt;
      exp_q.push_back('{d: 8'hF0, l: 1'b0});
      exp_q.push_back('{d: 8'h20, l: 1'b0});
      exp_q.push_back('{d: 8'h10, l: 1'b1});
      start_xfer(16'h0100, 8'd2, s0);
      wait_done(d0 + 1, 200, to);
      checks++;
      if (to) begin errors++; $display("FAIL csum_timeout got no done want done"); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (rp >= obs_q.size()) begin errors++; $display("FAIL csum_beat missing want %h", e); end
         else if (obs_q[rp] !== e) begin errors++; $display("FAIL csum_beat got %h want %h", obs_q[rp], e); end
         rp++;
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 7 + 3);
      ram[16'h0010] = 8'h11; ram[16'h0011] = 8'h22; ram[16'h0012] = 8'h33; ram[16'h0013] = 8'h44;
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_len_busy();
      test_wrap_latency();
      test_reset_mid();
`ifdef RAM_READER_CHECKSUM_EN
      test_checksum();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
